// File: rtl/clock_bcd_pkg.sv
// Shared types and constants for the clock BCD converter:
// field enum, field widths/limits, FSM state encoding.
package clock_bcd_pkg;

    typedef enum logic [2:0] {
        FLD_SEC,
        FLD_MIN,
        FLD_HOUR,
        FLD_DAY,
        FLD_MONTH,
        FLD_YEAR
    } fld_e;

    localparam int NUM_FLD     = 6;
    localparam int FLD_DIGITS  = 2;
    localparam int YEAR_DIGITS = 4;
    localparam int BCD_W       = 4 * YEAR_DIGITS;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int DAY_MIN   = 1;
    localparam int DAY_MAX   = 31;
    localparam int MONTH_MIN = 1;
    localparam int MONTH_MAX = 12;
    localparam int YEAR_MAX  = 9999;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_STORE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [4:0] fld_width(fld_e f, int year_w);
        logic [4:0] w;
        unique case (f)
            FLD_SEC:   w = 5'(SEC_W);
            FLD_MIN:   w = 5'(MIN_W);
            FLD_HOUR:  w = 5'(HOUR_W);
            FLD_DAY:   w = 5'(DAY_W);
            FLD_MONTH: w = 5'(MONTH_W);
            default:   w = 5'(year_w);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/clock_bcd_converter_dabble_core.sv
// Serial double-dabble engine: one 16-bit BCD register fed
// from a left-justified binary shift register.
module bcd_dabble_core
    import clock_bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-5:0] adj_lo;
    logic [2:0]       adj_top;

    always_comb begin
        adj_lo = '0;
        for (int i = 0; i < YEAR_DIGITS - 1; i++) begin
            adj_lo[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5)
                             ? bcd_q[4*i +: 4] + 4'd3
                             : bcd_q[4*i +: 4];
        end
        // The top digit's carry falls off the register, so only 3 bits matter.
        adj_top = bcd_q[BCD_W-2 -: 3]
                + ((bcd_q[BCD_W-1 -: 4] >= 4'd5) ? 3'd3 : 3'd0);

        bcd_d = bcd_q;
        bin_d = bin_q;
        if (load_i) begin
            bcd_d = '0;
            bin_d = bin_i;
        end else if (shift_en_i) begin
            bcd_d = {adj_top, adj_lo, bin_q[BIN_W-1]};
            bin_d = bin_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            bin_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/clock_bcd_converter.sv
// Converts captured time/date fields to 14 BCD digits via one shared
// double-dabble core. Optional range checking: BCD_RANGE_CHECK_EN.
module clock_bcd_converter
    import clock_bcd_pkg::*;
#(
    parameter int YEAR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        sec_bin,
    input  logic [5:0]        min_bin,
    input  logic [4:0]        hour_bin,
    input  logic [4:0]        day_bin,
    input  logic [3:0]        month_bin,
    input  logic [YEAR_W-1:0] year_bin,
    output logic              busy,
    output logic              valid,
    output logic [3:0]        sec_bcd1,
    output logic [3:0]        sec_bcd0,
    output logic [3:0]        min_bcd1,
    output logic [3:0]        min_bcd0,
    output logic [3:0]        hour_bcd1,
    output logic [3:0]        hour_bcd0,
    output logic [3:0]        day_bcd1,
    output logic [3:0]        day_bcd0,
    output logic [3:0]        month_bcd1,
    output logic [3:0]        month_bcd0,
    output logic [3:0]        year_bcd3,
    output logic [3:0]        year_bcd2,
    output logic [3:0]        year_bcd1,
    output logic [3:0]        year_bcd0,
    output logic              range_err
);

    localparam int D2_W = 4 * FLD_DIGITS;

    state_t            state_q, state_d;
    fld_e              fld_q, fld_d;
    logic [4:0]        bit_q, bit_d;
    logic [4:0]        fld_w;

    logic [5:0]        sec_s_q, min_s_q;
    logic [4:0]        hour_s_q, day_s_q;
    logic [3:0]        mon_s_q;
    logic [YEAR_W-1:0] year_s_q;

    logic              busy_q, valid_q;
    logic [D2_W-1:0]   bank_q [NUM_FLD-1];
    logic [BCD_W-1:0]  bank_yr_q;
    logic [D2_W-1:0]   out_q [NUM_FLD-1];
    logic [BCD_W-1:0]  out_yr_q;

    logic [YEAR_W-1:0] load_val;
    logic [BCD_W-1:0]  bcd;
    logic [NUM_FLD-1:0] bad;
    logic              capture;

    assign capture = (state_q == ST_IDLE) && start;
    assign fld_w   = fld_width(fld_q, YEAR_W);

    // Fields are left-justified so the core always shifts from its MSB.
    always_comb begin
        load_val = '0;
        unique case (fld_q)
            FLD_SEC:   load_val[YEAR_W-1 -: 6] = sec_s_q;
            FLD_MIN:   load_val[YEAR_W-1 -: 6] = min_s_q;
            FLD_HOUR:  load_val[YEAR_W-1 -: 5] = hour_s_q;
            FLD_DAY:   load_val[YEAR_W-1 -: 5] = day_s_q;
            FLD_MONTH: load_val[YEAR_W-1 -: 4] = mon_s_q;
            default:   load_val = year_s_q;
        endcase
    end

    bcd_dabble_core #(
        .BIN_W (YEAR_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == ST_LOAD),
        .shift_en_i (state_q == ST_SHIFT),
        .bin_i      (load_val),
        .bcd_o      (bcd)
    );

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    fld_d   = FLD_SEC;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                bit_d   = fld_w - 5'd1;
            end
            ST_SHIFT: begin
                if (bit_q == '0) state_d = ST_STORE;
                else             bit_d   = bit_q - 5'd1;
            end
            ST_STORE: begin
                if (fld_q == FLD_YEAR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                    fld_d   = fld_e'(fld_q + 3'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BCD_RANGE_CHECK_EN
    logic err_q;

    always_comb begin
        bad = '0;
        bad[FLD_SEC]   = int'(sec_s_q) > SEC_MAX;
        bad[FLD_MIN]   = int'(min_s_q) > MIN_MAX;
        bad[FLD_HOUR]  = int'(hour_s_q) > HOUR_MAX;
        bad[FLD_DAY]   = int'(day_s_q) < DAY_MIN
                      || int'(day_s_q) > DAY_MAX;
        bad[FLD_MONTH] = int'(mon_s_q) < MONTH_MIN
                      || int'(mon_s_q) > MONTH_MAX;
        bad[FLD_YEAR]  = int'(year_s_q) > YEAR_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err_q <= 1'b0;
        else if (state_q == ST_DONE) err_q <= |bad;
    end

    assign range_err = err_q;
`else
    assign bad       = '0;
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fld_q     <= FLD_SEC;
            bit_q     <= '0;
            sec_s_q   <= '0;
            min_s_q   <= '0;
            hour_s_q  <= '0;
            day_s_q   <= '0;
            mon_s_q   <= '0;
            year_s_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            bank_yr_q <= '0;
            out_yr_q  <= '0;
            for (int i = 0; i < NUM_FLD - 1; i++) begin
                bank_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            bit_q   <= bit_d;
            valid_q <= (state_q == ST_DONE);
            if (capture) begin
                sec_s_q  <= sec_bin;
                min_s_q  <= min_bin;
                hour_s_q <= hour_bin;
                day_s_q  <= day_bin;
                mon_s_q  <= month_bin;
                year_s_q <= year_bin;
                busy_q   <= 1'b1;
            end
            if (state_q == ST_STORE) begin
                if (fld_q == FLD_YEAR) bank_yr_q     <= bcd;
                else                   bank_q[fld_q] <= bcd[D2_W-1:0];
            end
            if (state_q == ST_DONE) begin
                busy_q   <= 1'b0;
                out_yr_q <= bad[FLD_YEAR] ? '1 : bank_yr_q;
                for (int i = 0; i < NUM_FLD - 1; i++) begin
                    out_q[i] <= bad[i] ? '1 : bank_q[i];
                end
            end
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign sec_bcd1   = out_q[FLD_SEC][7:4];
    assign sec_bcd0   = out_q[FLD_SEC][3:0];
    assign min_bcd1   = out_q[FLD_MIN][7:4];
    assign min_bcd0   = out_q[FLD_MIN][3:0];
    assign hour_bcd1  = out_q[FLD_HOUR][7:4];
    assign hour_bcd0  = out_q[FLD_HOUR][3:0];
    assign day_bcd1   = out_q[FLD_DAY][7:4];
    assign day_bcd0   = out_q[FLD_DAY][3:0];
    assign month_bcd1 = out_q[FLD_MONTH][7:4];
    assign month_bcd0 = out_q[FLD_MONTH][3:0];
    assign year_bcd3  = out_yr_q[15:12];
    assign year_bcd2  = out_yr_q[11:8];
    assign year_bcd1  = out_yr_q[7:4];
    assign year_bcd0  = out_yr_q[3:0];

endmodule

// File: tb/tb_clock_bcd_converter.sv
// Self-checking bench for clock_bcd_converter: table vectors, random
// conversions against a decimal-arithmetic model, and handshake corners.
module tb_clock_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  sec_bin = '0;
    logic [5:0]  min_bin = '0;
    logic [4:0]  hour_bin = '0;
    logic [4:0]  day_bin = '0;
    logic [3:0]  month_bin = '0;
    logic [13:0] year_bin = '0;
    logic        busy, valid, range_err;
    logic [3:0]  sec_bcd1, sec_bcd0, min_bcd1, min_bcd0;
    logic [3:0]  hour_bcd1, hour_bcd0, day_bcd1, day_bcd0;
    logic [3:0]  month_bcd1, month_bcd0;
    logic [3:0]  year_bcd3, year_bcd2, year_bcd1, year_bcd0;

    int errors = 0;
    int checks = 0;

    clock_bcd_converter #(.YEAR_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sec_bin    (sec_bin),
        .min_bin    (min_bin),
        .hour_bin   (hour_bin),
        .day_bin    (day_bin),
        .month_bin  (month_bin),
        .year_bin   (year_bin),
        .busy       (busy),
        .valid      (valid),
        .sec_bcd1   (sec_bcd1),
        .sec_bcd0   (sec_bcd0),
        .min_bcd1   (min_bcd1),
        .min_bcd0   (min_bcd0),
        .hour_bcd1  (hour_bcd1),
        .hour_bcd0  (hour_bcd0),
        .day_bcd1   (day_bcd1),
        .day_bcd0   (day_bcd0),
        .month_bcd1 (month_bcd1),
        .month_bcd0 (month_bcd0),
        .year_bcd3  (year_bcd3),
        .year_bcd2  (year_bcd2),
        .year_bcd1  (year_bcd1),
        .year_bcd0  (year_bcd0),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s, m, h, d, mo, y;
        logic [55:0] exp;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [55:0] dig();
        return {sec_bcd1, sec_bcd0, min_bcd1, min_bcd0,
                hour_bcd1, hour_bcd0, day_bcd1, day_bcd0,
                month_bcd1, month_bcd0,
                year_bcd3, year_bcd2, year_bcd1, year_bcd0};
    endfunction

    // Returns {range_err, 14 digits} from decimal arithmetic on the fields.
    function automatic logic [56:0] model(int s, int m, int h, int d,
                                          int mo, int y);
        logic [55:0] dg;
        logic        err;
        int          v[5];
        v   = '{s, m, h, d, mo};
        err = 1'b0;
        dg  = '0;
        for (int i = 0; i < 5; i++)
            dg[55-8*i -: 8] = {4'(v[i] / 10), 4'(v[i] % 10)};
        dg[15:0] = {4'((y / 1000) % 10), 4'((y / 100) % 10),
                    4'((y / 10) % 10), 4'(y % 10)};
`ifdef BCD_RANGE_CHECK_EN
        if (s > 59)              begin dg[55:48] = 8'hFF; err = 1'b1; end
        if (m > 59)              begin dg[47:40] = 8'hFF; err = 1'b1; end
        if (h > 23)              begin dg[39:32] = 8'hFF; err = 1'b1; end
        if (d < 1 || d > 31)     begin dg[31:24] = 8'hFF; err = 1'b1; end
        if (mo < 1 || mo > 12)   begin dg[23:16] = 8'hFF; err = 1'b1; end
        if (y > 9999)            begin dg[15:0] = 16'hFFFF; err = 1'b1; end
`endif
        return {err, dg};
    endfunction

    task automatic set_in(input int s, m, h, d, mo, y);
        sec_bin   = 6'(s);
        min_bin   = 6'(m);
        hour_bin  = 5'(h);
        day_bin   = 5'(d);
        month_bin = 4'(mo);
        year_bin  = 14'(y);
    endtask

    task automatic run_conv(input int s, m, h, d, mo, y,
                            output int lat, output logic busy_ok);
        @(negedge clk);
        set_in(s, m, h, d, mo, y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic conv_check(input string name, input int s, m, h, d,
                              input int mo, y);
        int          lat;
        logic        bok;
        logic [56:0] e;
        e = model(s, m, h, d, mo, y);
        run_conv(s, m, h, d, mo, y, lat, bok);
        check({name, " latency"}, 64'(lat), 64'd53);
        check({name, " busy during"}, 64'(bok), 64'd1);
        check({name, " busy at valid"}, 64'(busy), 64'd0);
        check({name, " digits"}, 64'(dig()), 64'(e[55:0]));
        check({name, " range_err"}, 64'(range_err), 64'(e[56]));
        @(posedge clk);
        #1;
        check({name, " valid pulse width"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int          q[$];
        int          lat, nv;
        logic        bok;
        logic [55:0] prev;
        logic [56:0] e;

        tbl[0] = '{59, 59, 23, 31, 12, 2024, 56'h59592331122024};
        tbl[1] = '{0, 0, 0, 1, 1, 0, 56'h00000001010000};
        tbl[2] = '{7, 30, 9, 15, 6, 1999, 56'h07300915061999};
        tbl[3] = '{45, 8, 17, 28, 2, 9999, 56'h45081728029999};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset digits", 64'(dig()), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset range_err", 64'(range_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_conv(tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].d,
                     tbl[i].mo, tbl[i].y, lat, bok);
            check($sformatf("tbl%0d latency", i), 64'(lat), 64'd53);
            check($sformatf("tbl%0d busy", i), 64'(bok), 64'd1);
            check($sformatf("tbl%0d digits", i), 64'(dig()), 64'(tbl[i].exp));
            check($sformatf("tbl%0d range_err", i), 64'(range_err), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d valid width", i), 64'(valid), 64'd0);
        end

        // Start held high: conversions back-to-back at 54-cycle spacing.
        @(negedge clk);
        set_in(12, 34, 5, 6, 7, 890);
        start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (valid) q.push_back(i);
        end
        start = 1'b0;
        check("held start pulses", 64'(q.size()), 64'd2);
        check("held start 1st", 64'(q.size() > 0 ? q[0] : -1), 64'd53);
        check("held start 2nd", 64'(q.size() > 1 ? q[1] : -1), 64'd107);
        check("held start digits", 64'(dig()), 64'h12340506070890);
        nv = 0;
        while (busy && nv < 100) begin
            @(posedge clk);
            #1;
            nv++;
        end
        check("held start drain", 64'(busy), 64'd0);

        // Start pulse while busy must not trigger another conversion.
        q.delete();
        @(negedge clk);
        set_in(1, 2, 3, 4, 5, 6);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 120; i++) begin
            @(posedge clk);
            #1;
            start = (i == 19);
            if (valid) q.push_back(i);
        end
        check("busy start pulses", 64'(q.size()), 64'd1);
        check("busy start time", 64'(q.size() > 0 ? q[0] : -1), 64'd53);

        conv_check("year12345", 10, 20, 10, 10, 10, 12345);
        conv_check("month0", 10, 20, 10, 10, 0, 2000);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        set_in(33, 44, 11, 22, 9, 4321);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset digits", 64'(dig()), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset range_err", 64'(range_err), 64'd0);
        nv = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("midreset no valid", 64'(nv), 64'd0);
        conv_check("after reset", 33, 44, 11, 22, 9, 4321);

        // Inputs change after capture; outputs hold until valid.
        prev = dig();
        e    = model(58, 1, 20, 3, 11, 1066);
        @(negedge clk);
        set_in(58, 1, 20, 3, 11, 1066);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5)
                set_in($urandom_range(0, 63), $urandom_range(0, 63),
                       $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 15), $urandom_range(0, 16383));
            if (lat == 52)
                check("hold before valid", 64'(dig()), 64'(prev));
        end
        check("capture latency", 64'(lat), 64'd53);
        check("capture digits", 64'(dig()), 64'(e[55:0]));

        for (int i = 0; i < 10; i++) begin
            conv_check($sformatf("rand%0d", i),
                       $urandom_range(0, 63), $urandom_range(0, 63),
                       $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 15), $urandom_range(0, 16383));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
